// File: rtl/req_priority_encoder.sv
// req_priority_encoder
//   Sequential N:W priority encoder. Request pulses are captured into sticky
//   pending bits. The index of the highest-numbered pending request is
//   presented on a valid/ready handshake, one index per transfer.
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset
//   req      in   [N-1:0] request lines; a bit high at an edge registers one event
//   ready    in   consumer accepts enc_out when valid && ready at an edge
//   enc_out  out  [W-1:0] index being presented (meaningful only while valid)
//   valid    out  enc_out holds a pending request index
//   pending  out  [N-1:0] registered sticky pending bits
//   ovf      out  sticky: a request hit a bit that was already pending
//
// Handshake: a transfer happens at a rising edge where valid && ready are both
// high. Once valid rises, enc_out and valid stay stable until that transfer
// (no preemption by higher-priority arrivals). ready while valid=0 is ignored.
//
// The FSM has two states and valid is registered alongside it, so valid is
// high exactly when the FSM is in PRESENT; valid doubles as the state view.

module req_priority_encoder #(
  parameter int W = 2,
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         ready,
  output logic [W-1:0] enc_out,
  output logic         valid,
  output logic [N-1:0] pending,
  output logic         ovf
);

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   enc_q, enc_d;
  logic           valid_q, valid_d;
  logic [N-1:0]   pending_q, pending_d;
  logic           ovf_q, ovf_d;

  logic           xfer;
  logic [N-1:0]   clr;
  logic [N-1:0]   kept;

  // Highest set index wins; ascending scan lets the last hit overwrite.
  function automatic logic [W-1:0] top_index(input logic [N-1:0] v);
    logic [W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (v[i]) idx = W'(i);
    end
    return idx;
  endfunction

  always_comb begin
    xfer      = valid_q && ready;
    clr       = xfer ? (N'(1) << enc_q) : '0;
    kept      = pending_q & ~clr;
    // A request landing on the bit being accepted this edge is a fresh event,
    // so only bits that survive the accept count as overflow.
    pending_d = kept | req;
    ovf_d     = ovf_q | (|(req & kept));

    state_d   = state_q;
    enc_d     = enc_q;
    valid_d   = valid_q;

    case (state_q)
      IDLE: begin
        // Uses the registered pending value: a request seen at edge k is
        // presented from edge k+1.
        if (pending_q != '0) begin
          enc_d   = top_index(pending_q);
          valid_d = 1'b1;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (xfer) begin
          if (pending_d != '0) begin
            enc_d = top_index(pending_d);
          end else begin
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      enc_q     <= '0;
      valid_q   <= 1'b0;
      pending_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      enc_q     <= enc_d;
      valid_q   <= valid_d;
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
    end
  end

  assign enc_out = enc_q;
  assign valid   = valid_q;
  assign pending = pending_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_req_priority_encoder.sv
// Bench for req_priority_encoder: behavioural reference model compared every
// cycle, a transfer scoreboard fed with hand-computed index sequences, and
// literal checks at key points of each directed scenario.

module tb_req_priority_encoder;

  localparam int W = 2;
  localparam int N = 4;

  // ---------------- clock / reset ----------------
  logic         clk;
  logic         rst;
  logic [N-1:0] req;
  logic         ready;
  logic [W-1:0] enc_out;
  logic         valid;
  logic [N-1:0] pending;
  logic         ovf;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  req_priority_encoder #(.W(W), .N(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .ready   (ready),
    .enc_out (enc_out),
    .valid   (valid),
    .pending (pending),
    .ovf     (ovf)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Pending requests are a bit set; the presented request is one index plus a
  // flag. Rules: an accepted index leaves the set, new requests join it,
  // a request on a still-present member is an overflow. The presented index
  // changes only when nothing is presented or the current one is accepted.
  logic [N-1:0] m_pend;
  logic [W-1:0] m_enc;
  logic         m_valid;
  logic         m_ovf;

  function automatic logic [W-1:0] highest(input logic [N-1:0] v);
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) return W'(i);
    end
    return '0;
  endfunction

  always @(posedge clk) begin
    logic         accepted;
    logic [N-1:0] remaining;
    logic [N-1:0] next_set;
    if (rst) begin
      m_pend  = '0;
      m_enc   = '0;
      m_valid = 1'b0;
      m_ovf   = 1'b0;
    end else begin
      accepted = m_valid && ready;
      for (int i = 0; i < N; i++) begin
        remaining[i] = m_pend[i] && !(accepted && (i == int'(m_enc)));
        if (req[i] && remaining[i]) m_ovf = 1'b1;
      end
      next_set = remaining | req;
      if (!m_valid) begin
        if (m_pend != '0) begin
          m_enc   = highest(m_pend);
          m_valid = 1'b1;
        end
      end else if (accepted) begin
        if (next_set != '0) m_enc = highest(next_set);
        else m_valid = 1'b0;
      end
      m_pend = next_set;
    end
  end

  // ---------------- compare process / scoreboard ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (chk_en) begin
      check("model_valid", valid, m_valid);
      check("model_pending", pending, m_pend);
      check("model_ovf", ovf, m_ovf);
      check("model_enc", enc_out, m_enc);
      // Inputs are stable here until the next edge, so this is a transfer.
      if (!rst && valid && ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL xfer: unexpected index %0d, none expected at %0t", enc_out, $time);
        end else begin
          e = exp_q.pop_front();
          if (enc_out !== e) begin
            errors++;
            $display("FAIL xfer: got index %0d expected %0d at %0t", enc_out, e, $time);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic [N-1:0] r, input logic rd);
    req   = r;
    ready = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [N-1:0] r);
    rst   = 1'b1;
    req   = r;
    ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    req = '0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst   = 1'b1;
    req   = '0;
    ready = 1'b0;
    do_reset('0);
    chk_en = 1'b1;

    // Reset state
    check("rst_valid", valid, 0);
    check("rst_enc", enc_out, 0);
    check("rst_pending", pending, 0);
    check("rst_ovf", ovf, 0);

    // Idle
    for (int i = 0; i < 10; i++) begin
      cycle(4'b0000, 1'b0);
      check("idle_valid", valid, 0);
      check("idle_pending", pending, 0);
      check("idle_enc", enc_out, 0);
    end

    // Single request
    exp_q.push_back(2'd2);
    cycle(4'b0100, 1'b1);
    check("single_pend_k", pending, 4'b0100);
    check("single_valid_k", valid, 0);
    cycle(4'b0000, 1'b1);
    check("single_valid_k1", valid, 1);
    check("single_enc_k1", enc_out, 2);
    cycle(4'b0000, 1'b1);
    check("single_valid_k2", valid, 0);
    check("single_pend_k2", pending, 4'b0000);

    // Multi-request burst: 3, 1, 0
    exp_q.push_back(2'd3);
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd0);
    cycle(4'b1011, 1'b1);
    cycle(4'b0000, 1'b1);
    check("burst_enc0", enc_out, 3);
    cycle(4'b0000, 1'b1);
    check("burst_enc1", enc_out, 1);
    check("burst_pend1", pending, 4'b0011);
    cycle(4'b0000, 1'b1);
    check("burst_enc2", enc_out, 0);
    check("burst_valid2", valid, 1);
    cycle(4'b0000, 1'b1);
    check("burst_valid_end", valid, 0);
    check("burst_pend_end", pending, 4'b0000);
    check("burst_ovf", ovf, 0);

    // Hold / no preemption
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd3);
    cycle(4'b0010, 1'b0);
    cycle(4'b0000, 1'b0);
    check("hold_enc", enc_out, 1);
    cycle(4'b1000, 1'b0);
    check("hold_pend", pending, 4'b1010);
    for (int i = 0; i < 5; i++) begin
      cycle(4'b0000, 1'b0);
      check("hold_stable_enc", enc_out, 1);
      check("hold_stable_valid", valid, 1);
    end
    cycle(4'b0000, 1'b1);
    check("hold_next_enc", enc_out, 3);
    check("hold_next_valid", valid, 1);
    cycle(4'b0000, 1'b1);
    check("hold_end_valid", valid, 0);

    // Same-cycle accept and re-request on bit 0
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd0);
    cycle(4'b0001, 1'b0);
    cycle(4'b0000, 1'b0);
    check("rereq_enc", enc_out, 0);
    cycle(4'b0001, 1'b1);
    check("rereq_valid", valid, 1);
    check("rereq_enc_again", enc_out, 0);
    check("rereq_pend", pending, 4'b0001);
    check("rereq_ovf", ovf, 0);
    cycle(4'b0000, 1'b1);
    check("rereq_end_valid", valid, 0);

    // Overflow: repeat pulses on a pending, unaccepted bit
    exp_q.push_back(2'd1);
    cycle(4'b0010, 1'b0);
    cycle(4'b0000, 1'b0);
    check("ovf_before", ovf, 0);
    cycle(4'b0010, 1'b0);
    check("ovf_set", ovf, 1);
    check("ovf_pend", pending, 4'b0010);
    cycle(4'b0000, 1'b1);
    check("ovf_single_xfer", valid, 0);
    cycle(4'b0000, 1'b1);
    check("ovf_no_second", valid, 0);
    check("ovf_sticky", ovf, 1);

    // Reset mid-operation
    cycle(4'b1010, 1'b0);
    cycle(4'b0000, 1'b0);
    check("mid_enc", enc_out, 3);
    check("mid_valid", valid, 1);
    do_reset(4'b0100);
    check("mid_rst_valid", valid, 0);
    check("mid_rst_pend", pending, 4'b0000);
    check("mid_rst_ovf", ovf, 0);
    for (int i = 0; i < 5; i++) begin
      cycle(4'b0000, 1'b1);
      check("mid_no_xfer", valid, 0);
    end

    // Every expected transfer must have been observed
    check("xfer_queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety net in case the stimulus ever stalls
  initial begin
    #100000;
    errors++;
    $display("FAIL timeout: simulation exceeded time budget");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
